eff_clip_gen: RTL and testbench

//   Parametrised successor to the fixed-level hard clipper in the audio effect chain.

---
 rtl/eff_clip_gen.sv | 93 +++++++++
 tb/tb_eff_clip_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/eff_clip_gen.sv
// eff_clip_gen: two-stage offset-binary clipper (bypass/hard/soft/fold) with clip hold indicator and saturating clip counter
module eff_clip_gen #(
  parameter int DATA_W         = 8,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int HOLD_MS        = 100,
  parameter int DEFAULT_THRESH = 72
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] receive_byte,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-2:0] i_thresh,
  input  logic              i_thresh_load,
  input  logic              i_cnt_clr,
  output logic              o_valid,
  output logic [DATA_W-1:0] clipping_byte,
  output logic              o_clip,
  output logic [15:0]       o_clip_count
);
  localparam int HOLD_RAW = CLK_FREQ / 1000 * HOLD_MS;
  localparam int HOLD_CYC = HOLD_RAW < 1 ? 1 : HOLD_RAW;
  localparam int HW       = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W:0] MAXP = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic [1:0] BYP = 2'd0, HARD = 2'd1, SOFT = 2'd2;
  logic [DATA_W-2:0]       thresh_q, t_q;
  logic                    v1_q, neg_q, vo_q, clip_q, clip_d, hit, clipped;
  logic [DATA_W-1:0]       s_d, s_q, abs_d, abs_q, out_q, out_d;
  logic [1:0]              mode_q;
  logic [HW-1:0]           hold_q, hold_d;
  logic [15:0]             cnt_q, cnt_d;
  logic signed [DATA_W:0]  sx, tx, ax, mag, fold, foldc, res;
  // offset removal and magnitude for the incoming sample
  always_comb begin
    s_d   = receive_byte - MID;
    abs_d = s_d[DATA_W-1] ? -s_d : s_d;
  end
  // runtime threshold; a load takes effect for samples after the loading edge
  always_ff @(posedge i_clk) begin
    if (i_rst) thresh_q <= (DATA_W-1)'(DEFAULT_THRESH);
    else if (i_thresh_load) thresh_q <= i_thresh;
  end
  // stage 1: capture signed sample, magnitude, sign, mode and the threshold in force
  always_ff @(posedge i_clk) begin
    if (i_rst) v1_q <= 1'b0;
    else v1_q <= data_valid;
    if (data_valid) begin
      s_q    <= s_d;
      abs_q  <= abs_d;
      neg_q  <= s_d[DATA_W-1];
      mode_q <= i_mode;
      t_q    <= thresh_q;
    end
  end
  // stage 2 arithmetic at DATA_W+1 bits, plus hold and counter next state
  always_comb begin
    sx      = {s_q[DATA_W-1], s_q};
    tx      = {2'b00, t_q};
    ax      = {1'b0, abs_q};
    clipped = (mode_q != BYP) && (ax > tx);
    mag     = tx + ((ax - tx) >>> 2);
    fold    = neg_q ? -(tx <<< 1) - sx : (tx <<< 1) - sx;
    foldc   = fold > tx ? tx : fold < -tx ? -tx : fold;
    res     = !clipped ? sx : mode_q == HARD ? (neg_q ? -tx : tx) :
              mode_q == SOFT ? (neg_q ? -mag : (mag > MAXP ? MAXP : mag)) : foldc;
    hit     = v1_q && clipped;
    out_d   = v1_q ? DATA_W'(res + (DATA_W+1)'(MID)) : out_q;
    hold_d  = hit ? HW'(HOLD_CYC - 1) : hold_q != '0 ? hold_q - 1'b1 : hold_q;
    clip_d  = hit || (clip_q && hold_q != '0);
    cnt_d   = i_cnt_clr ? '0 : (hit && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  // stage 2 registers: output sample, strobe, clip hold and clip counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q  <= MID;
      vo_q   <= 1'b0;
      clip_q <= 1'b0;
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      vo_q   <= v1_q;
      clip_q <= clip_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end
  assign o_valid       = vo_q;
  assign clipping_byte = out_q;
  assign o_clip        = clip_q;
  assign o_clip_count  = cnt_q;
endmodule

// File: tb/tb_eff_clip_gen.sv
// tb_eff_clip_gen: directed self-checking bench for eff_clip_gen at DATA_W=8, 1 ms hold at 1 MHz
module tb_eff_clip_gen;
  logic clk = 1'b0, rst = 1'b1, dv = 1'b0, tl = 1'b0, clr = 1'b0;
  logic [7:0] rb = 8'd128;
  logic [1:0] md = 2'd0;
  logic [6:0] th = 7'd0;
  logic ov, oc;
  logic [7:0] cb;
  logic [15:0] cnt;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  eff_clip_gen #(.DATA_W(8), .CLK_FREQ(1_000_000), .HOLD_MS(1), .DEFAULT_THRESH(72)) dut (
    .i_clk(clk), .i_rst(rst), .data_valid(dv), .receive_byte(rb), .i_mode(md),
    .i_thresh(th), .i_thresh_load(tl), .i_cnt_clr(clr),
    .o_valid(ov), .clipping_byte(cb), .o_clip(oc), .o_clip_count(cnt)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cb !== 8'd128) begin n_bad++; $display("FAIL reset_byte: got %0d want 128", cb); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ov); end
    n_cmp++; if (oc !== 1'b0) begin n_bad++; $display("FAIL reset_clip: got %b want 0", oc); end
    n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt); end
  endtask

  task automatic test_hard;
    logic [7:0] din [5] = '{8'd128, 8'd200, 8'd201, 8'd255, 8'd0};
    logic [7:0] exp [5] = '{8'd128, 8'd200, 8'd200, 8'd200, 8'd56};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); dv = 1'b1; rb = din[i]; md = 2'd1;
      @(negedge clk); dv = 1'b0; md = 2'd0;
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL hard_early[%0d]: got %b want 0", i, ov); end
      @(negedge clk);
      n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL hard_valid[%0d]: got %b want 1", i, ov); end
      n_cmp++; if (cb !== exp[i]) begin n_bad++; $display("FAIL hard_out[%0d]: got %0d want %0d", i, cb, exp[i]); end
    end
    @(negedge clk);
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL hard_strobe_len: got %b want 0", ov); end
    n_cmp++; if (cnt !== 16'd3) begin n_bad++; $display("FAIL hard_count: got %0d want 3", cnt); end
  endtask

  task automatic test_modes;
    logic [1:0] mds [6] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [7:0] din [6] = '{8'd255, 8'd0, 8'd190, 8'd210, 8'd0, 8'd255};
    logic [7:0] exp [6] = '{8'd213, 8'd42, 8'd190, 8'd190, 8'd112, 8'd255};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); dv = 1'b1; rb = din[i]; md = mds[i];
      @(negedge clk); dv = 1'b0; md = 2'd1;
      @(negedge clk);
      n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL mode_valid[%0d]: got %b want 1", i, ov); end
      n_cmp++; if (cb !== exp[i]) begin n_bad++; $display("FAIL mode_out[%0d]: got %0d want %0d", i, cb, exp[i]); end
    end
    n_cmp++; if (cnt !== 16'd7) begin n_bad++; $display("FAIL mode_count: got %0d want 7", cnt); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] mds [8] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic [7:0] din [8] = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128, 8'd0};
    logic [7:0] exp [8] = '{8'd200, 8'd160, 8'd96, 8'd96, 8'd160, 8'd183, 8'd128, 8'd0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i - 2, ov); end
        n_cmp++; if (cb !== exp[i-2]) begin n_bad++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i - 2, cb, exp[i-2]); end
      end
      if (i < 8) begin
        dv = 1'b1; rb = din[i]; md = mds[i]; tl = (i == 0); th = 7'd32;
      end else begin
        dv = 1'b0; tl = 1'b0; md = 2'd0;
      end
    end
    @(negedge clk);
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL b2b_tail: got %b want 0", ov); end
    n_cmp++; if (cnt !== 16'd13) begin n_bad++; $display("FAIL b2b_count: got %0d want 13", cnt); end
  endtask

  task automatic test_hold;
    int hi;
    repeat (1100) @(negedge clk);
    n_cmp++; if (oc !== 1'b0) begin n_bad++; $display("FAIL hold_idle: got %b want 0", oc); end
    for (int r = 0; r < 2; r++) begin
      hi = 0;
      @(negedge clk); dv = 1'b1; rb = 8'd255; md = 2'd1;
      for (int k = 1; k <= 2000; k++) begin
        @(negedge clk);
        dv = (r == 1 && k == 500);
        hi += int'(oc);
      end
      n_cmp++;
      if (hi != (r == 0 ? 1000 : 1500)) begin
        n_bad++; $display("FAIL hold_len[%0d]: got %0d want %0d", r, hi, r == 0 ? 1000 : 1500);
      end
    end
    @(negedge clk); dv = 1'b1; rb = 8'd255; md = 2'd1;
    @(negedge clk); dv = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL clr_valid: got %b want 1", ov); end
    n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL clr_count: got %0d want 0", cnt); end
  endtask

  task automatic test_saturate;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      if (i == 100) begin
        n_cmp++; if (cnt !== 16'd99) begin n_bad++; $display("FAIL sat_mid: got %0d want 99", cnt); end
      end
      dv = 1'b1; rb = 8'd0; md = 2'd1;
    end
    @(negedge clk); dv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_count: got %0d want 65535", cnt); end
  endtask

  task automatic test_reset_flight;
    @(negedge clk); dv = 1'b1; rb = 8'd255; md = 2'd1;
    @(negedge clk); rb = 8'd0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; dv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL flight_valid[%0d]: got %b want 0", k, ov); end
      @(negedge clk);
    end
    n_cmp++; if (cb !== 8'd128) begin n_bad++; $display("FAIL flight_byte: got %0d want 128", cb); end
    n_cmp++; if (cnt !== 16'd0) begin n_bad++; $display("FAIL flight_count: got %0d want 0", cnt); end
    n_cmp++; if (oc !== 1'b0) begin n_bad++; $display("FAIL flight_clip: got %b want 0", oc); end
    dv = 1'b1; rb = 8'd255; md = 2'd1;
    @(negedge clk); dv = 1'b0;
    @(negedge clk);
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL thr_valid: got %b want 1", ov); end
    n_cmp++; if (cb !== 8'd200) begin n_bad++; $display("FAIL thr_default: got %0d want 200", cb); end
  endtask

  initial begin
    test_reset;
    test_hard;
    test_modes;
    test_back_to_back;
    test_hold;
    test_saturate;
    test_reset_flight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
